// File: rtl/stochastic_sched_pkg.sv
// stochastic_sched_pkg: shared states, LFSR taps, default seeds and count scaling for the stochastic sequencer
package stochastic_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] DEF_SEED_A = 16'hACE1;
  localparam logic [15:0] DEF_SEED_B = 16'h1D2C;
  localparam logic [15:0] DEF_SEED_R = 16'h7A31;
  function automatic int ones_shift(input int len, input int pix_w);
    return $clog2(len) - pix_w;
  endfunction
endpackage

// File: rtl/sc_lfsr16.sv
// sc_lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with seed reload and step enable
module sc_lfsr16
  import stochastic_sched_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_SEED_A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  output logic [15:0] o_state
);
  logic [15:0] r_state;
  logic        w_fb;
  assign w_fb = ^(r_state & LFSR_TAPS);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= SEED;
    else if (i_load) r_state <= SEED;
    else if (i_step) r_state <= {r_state[14:0], w_fb};
  assign o_state = r_state;
endmodule

// File: rtl/stochastic_sched.sv
// stochastic_sched: turns a 3x3 window into stochastic streams, runs the datapath and counts its ones into an edge pixel
module stochastic_sched
  import stochastic_sched_pkg::*;
#(
  parameter int          PIX_W      = 8,
  parameter int          STREAM_LEN = 256,
  parameter int          DP_LAT     = 1,
  parameter logic [15:0] SEED_A     = DEF_SEED_A,
  parameter logic [15:0] SEED_B     = DEF_SEED_B,
  parameter logic [15:0] SEED_R     = DEF_SEED_R
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*PIX_W-1:0] in_win,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pix,
  output logic               busy,
  output logic [7:0]         sc_z_1,
  output logic [7:0]         sc_z_2,
  output logic [4:0]         sc_r,
  output logic               sc_en,
  input  logic               sc_z
);
  localparam int CW = $clog2(STREAM_LEN);
  localparam int SH = ones_shift(STREAM_LEN, PIX_W);
  localparam int PW = DP_LAT > 0 ? DP_LAT : 1;
  localparam logic [CW:0] PIX_MAX = (CW+1)'((1 << PIX_W) - 1);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [CW:0]        r_ones;
  logic [8*PIX_W-1:0] r_win;
  logic [PIX_W-1:0]   r_pix;
  logic [PW-1:0]      r_en_d;
  logic [15:0]        w_a, w_b, w_rr;
  logic               w_run, w_accept, w_en_dl, w_last_run, w_last_drain, w_fin;
  logic [CW:0]        w_ones_nx, w_sh;
  logic [PIX_W-1:0]   w_pix_nx;
  logic [7:0]         w_z1, w_z2;
  logic [4:0]         w_r;
  logic               w_unused;
  assign w_run    = r_state == RUN;
  assign w_accept = in_valid && r_state == IDLE;
  sc_lfsr16 #(.SEED(SEED_A)) u_lfsr_a (.clk, .rst, .i_load(w_accept), .i_step(w_run), .o_state(w_a));
  sc_lfsr16 #(.SEED(SEED_B)) u_lfsr_b (.clk, .rst, .i_load(w_accept), .i_step(w_run), .o_state(w_b));
  sc_lfsr16 #(.SEED(SEED_R)) u_lfsr_r (.clk, .rst, .i_load(w_accept), .i_step(w_run), .o_state(w_rr));
  always_comb begin
    w_z1 = '0;
    w_z2 = '0;
    w_r  = '0;
    for (int i = 0; i < 8; i++) begin
      w_z1[i] = w_run && (w_a[PIX_W-1:0] < r_win[i*PIX_W +: PIX_W]);
      w_z2[i] = w_run && (w_b[15 -: PIX_W] < r_win[i*PIX_W +: PIX_W]);
    end
    for (int k = 0; k < 5; k++) w_r[k] = w_run && w_rr[3*k];
  end
  // Ones are sampled on the datapath-aligned copy of sc_en, so the last bit lands while still in DRAIN
  if (DP_LAT == 0) begin : g_nolat
    assign w_en_dl = w_run;
  end else begin : g_lat
    assign w_en_dl = r_en_d[PW-1];
  end
  assign w_ones_nx    = r_ones + (CW+1)'(w_en_dl && sc_z);
  assign w_sh         = w_ones_nx >> SH;
  assign w_pix_nx     = w_sh > PIX_MAX ? PIX_W'(PIX_MAX) : PIX_W'(w_sh);
  assign w_last_run   = w_run && r_cnt == CW'(STREAM_LEN - 1);
  assign w_last_drain = r_state == DRAIN && r_cnt == CW'(DP_LAT - 1);
  assign w_fin        = (w_last_run && DP_LAT == 0) || w_last_drain;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ones  <= '0;
      r_win   <= '0;
      r_pix   <= '0;
      r_en_d  <= '0;
    end else begin
      r_en_d <= (r_en_d << 1) | PW'(w_run);
      r_ones <= w_accept ? '0 : w_ones_nx;
      if (w_fin) r_pix <= w_pix_nx;
      case (r_state)
        IDLE: if (in_valid) begin
          r_state <= RUN;
          r_cnt   <= '0;
          r_win   <= in_win;
        end
        RUN: begin
          r_cnt <= w_last_run ? '0 : r_cnt + 1'b1;
          if (w_last_run) r_state <= DP_LAT == 0 ? DONE : DRAIN;
        end
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_drain) r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign out_valid = r_state == DONE;
  assign out_pix   = r_pix;
  assign sc_z_1    = w_z1;
  assign sc_z_2    = w_z2;
  assign sc_r      = w_r;
  assign sc_en     = w_run;
  assign w_unused  = ^{w_a[15:PIX_W], w_b[15-PIX_W:0], w_rr[15:13], w_rr[11:10], w_rr[8:7],
                       w_rr[5:4], w_rr[2:1], r_en_d};
endmodule

// File: tb/tb_stochastic_sched.sv
// tb_stochastic_sched: directed transactions against a transaction-level model with a stub edge datapath
module tb_stochastic_sched;
  localparam int L = 256;
  localparam int D = 1;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [63:0] in_win = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [7:0]  out_pix;
  logic        busy;
  logic [7:0]  sc_z_1, sc_z_2;
  logic [4:0]  sc_r;
  logic        sc_en;
  logic        stub_q = 0;
  int          mode = 1;
  int          total = 0;
  int          bad = 0;
  bit          started = 0;
  logic [15:0] seq_a [L];
  logic [15:0] seq_b [L];
  logic [15:0] seq_r [L];
  bit          m_busy = 0;
  int          m_cyc = 0;
  int          m_acc = 0;
  int          m_exp = 0;
  logic [63:0] m_win = '0;
  logic [7:0]  m_prev = '0;
  int          acc1, acc2;
  logic [7:0]  acc_or;
  int          cd, cs;
  bit          crun, cdone;

  stochastic_sched #(.PIX_W(8), .STREAM_LEN(L), .DP_LAT(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .busy(busy),
    .sc_z_1(sc_z_1), .sc_z_2(sc_z_2), .sc_r(sc_r), .sc_en(sc_en), .sc_z(stub_q));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1]};
  endfunction
  function automatic logic [7:0] enc(input logic [63:0] w, input logic [7:0] lv);
    logic [7:0] z;
    for (int i = 0; i < 8; i++) z[i] = lv < w[8*i +: 8];
    return z;
  endfunction
  function automatic logic [4:0] rsel(input int s);
    return {seq_r[s][12], seq_r[s][9], seq_r[s][6], seq_r[s][3], seq_r[s][0]};
  endfunction
  // Stub edge datapath: stream-1 left column minus right column, row picked by r1:r0
  function automatic logic dp_f(input logic [7:0] z, input logic [4:0] r);
    int li, ri;
    li = r[1:0] == 2'd0 ? 0 : r[1:0] == 2'd2 ? 5 : 3;
    ri = r[1:0] == 2'd0 ? 2 : r[1:0] == 2'd2 ? 7 : 4;
    return z[li] ^ z[ri];
  endfunction
  function automatic int exp_ones(input logic [63:0] w, input int md);
    int n = 0;
    if (md == 0) return 0;
    if (md == 1) return L;
    if (md == 2) return L / 2;
    for (int s = 0; s < L; s++) n += int'(dp_f(enc(w, seq_a[s][7:0]), rsel(s)));
    return n;
  endfunction
  function automatic logic [7:0] sat(input int n);
    return n > 255 ? 8'd255 : 8'(n);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) stub_q <= mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? ~stub_q : dp_f(sc_z_1, sc_r);

  // Transaction model: timing derived from edges elapsed since the accept edge
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_busy <= 0;
      m_prev <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!m_busy && in_valid) begin
        m_busy <= 1;
        m_acc  <= m_cyc + 1;
        m_win  <= in_win;
        m_exp  <= exp_ones(in_win, mode);
      end else if (m_busy && m_cyc - m_acc >= L + D && out_ready) begin
        m_busy <= 0;
        m_prev <= sat(m_exp);
      end
    end

  always @(negedge clk) if (started) begin
    cd    = m_cyc - m_acc;
    crun  = m_busy && cd < L;
    cdone = m_busy && cd >= L + D;
    cs    = crun ? cd : 0;
    chk("in_ready", in_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, cdone);
    chk("out_pix", out_pix, cdone ? sat(m_exp) : m_prev);
    chk("sc_en", sc_en, crun);
    chk("sc_z_1", sc_z_1, crun ? enc(m_win, seq_a[cs][7:0]) : 8'h0);
    chk("sc_z_2", sc_z_2, crun ? enc(m_win, seq_b[cs][15:8]) : 8'h0);
    chk("sc_r", sc_r, crun ? rsel(cs) : 5'h0);
    if (crun) begin
      acc1   = (cd == 0 ? 0 : acc1) + int'(sc_z_1[0]);
      acc2   = (cd == 0 ? 0 : acc2) + int'(sc_z_2[7]);
      acc_or = (cd == 0 ? 8'h0 : acc_or) | sc_z_1 | sc_z_2;
    end
  end

  task automatic send(input logic [63:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    in_win   = w;
    do begin
      @(negedge clk);
      n++;
    end while (!m_busy && n < 20);
    in_valid = 0;
    in_win   = ~w;
    chk("accept", busy, 1);
  endtask
  task automatic wait_done(output int k);
    k = 0;
    while (!out_valid && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("done_wait", out_valid, 1);
  endtask

  initial begin
    int k, na, nb;
    logic [7:0] p;
    seq_a[0] = 16'hACE1;
    seq_b[0] = 16'h1D2C;
    seq_r[0] = 16'h7A31;
    for (int s = 1; s < L; s++) begin
      seq_a[s] = lfsr_next(seq_a[s-1]);
      seq_b[s] = lfsr_next(seq_b[s-1]);
      seq_r[s] = lfsr_next(seq_r[s-1]);
    end
    #1 rst = 0;
    started = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    mode = 1;
    send(64'h0123456789ABCDEF);
    wait_done(k);
    chk("latency_edges", k + 1, 258);
    chk("pix_all_ones", out_pix, 8'd255);
    mode = 0;
    send(64'hFFEEDDCCBBAA9988);
    wait_done(k);
    chk("pix_all_zero", out_pix, 8'd0);
    mode = 2;
    send(64'h1122334455667788);
    wait_done(k);
    chk("pix_toggle", out_pix, 8'd128);
    mode = 3;
    send(64'h0);
    wait_done(k);
    chk("win0_streams", acc_or, 8'h0);
    chk("win0_pix", out_pix, 8'd0);
    send({8{8'hFF}});
    wait_done(k);
    na = 0;
    nb = 0;
    for (int s = 0; s < L; s++) begin
      na += int'(seq_a[s][7:0] != 8'hFF);
      nb += int'(seq_b[s][15:8] != 8'hFF);
    end
    chk("win255_ones_a", acc1, na);
    chk("win255_ones_b", acc2, nb);
    chk("win255_floor", acc1 >= 248 && acc2 >= 248, 1);
    send({8{8'h80}});
    wait_done(k);
    chk("uniform128_pix", out_pix, 8'd0);
    send(64'h0000FF00FF0000FF);
    wait_done(k);
    chk("edge_pix_min", out_pix >= 8'd192, 1);
    mode = 1;
    out_ready = 0;
    send(64'h5555AAAA5555AAAA);
    wait_done(k);
    p = out_pix;
    in_valid = 1;
    in_win = 64'h0F0F0F0F0F0F0F0F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_pix", out_pix, p);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("hs_ready", in_ready, 1);
    chk("hs_valid", out_valid, 0);
    @(negedge clk);
    chk("second_accept", busy, 1);
    in_valid = 0;
    wait_done(k);
    chk("second_pix", out_pix, 8'd255);
    mode = 3;
    send(64'h0000FF00FF0000FF);
    repeat (100) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", sc_en, 0);
    chk("rst_pix", out_pix, 8'd0);
    rst = 1;
    send(64'h0000FF00FF0000FF);
    wait_done(k);
    chk("rerun_pix_min", out_pix >= 8'd192, 1);
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
